// File: rtl/id_stage_if.sv
// IF/ID inputs, writeback port and ID/EX outputs of the instruction-decode stage.
// The stage uses the slave modport; the fetch/execute side uses master.
interface id_stage_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] PC_in;
    logic [31:0]       Instruction;
    logic              freeze;
    logic              flush;
    logic              hazard;
    logic [3:0]        SR;
    logic              WB_WB_EN;
    logic [3:0]        WB_Dest;
    logic [DATA_W-1:0] WB_Value;

    logic [3:0]        src1;
    logic [3:0]        src2;
    logic              Two_src;

    logic              WB_EN;
    logic              MEM_R_EN;
    logic              MEM_W_EN;
    logic              B;
    logic              S;
    logic [3:0]        EXE_CMD;
    logic [DATA_W-1:0] Val_Rn;
    logic [DATA_W-1:0] Val_Rm;
    logic              imm;
    logic [11:0]       Shift_operand;
    logic [23:0]       Signed_imm_24;
    logic [3:0]        Dest;
    logic [DATA_W-1:0] PC_out;

    modport slave (
        input  PC_in, Instruction, freeze, flush, hazard, SR,
               WB_WB_EN, WB_Dest, WB_Value,
        output src1, src2, Two_src,
               WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD,
               Val_Rn, Val_Rm, imm, Shift_operand, Signed_imm_24, Dest, PC_out
    );

    modport master (
        output PC_in, Instruction, freeze, flush, hazard, SR,
               WB_WB_EN, WB_Dest, WB_Value,
        input  src1, src2, Two_src,
               WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD,
               Val_Rn, Val_Rm, imm, Shift_operand, Signed_imm_24, Dest, PC_out
    );
endinterface

// File: rtl/id_stage.sv
// Instruction decode: control decode, condition check, 15-entry register file
// with write-through bypass, and the registered ID/EX bundle.
module id_stage #(
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = 15
) (
    input  logic        clk,
    input  logic        rst,
    id_stage_if.slave   bus
);
    logic [DATA_W-1:0] rf [REG_COUNT];

    logic [3:0]  cond_p0, opcode_p0, rn_p0, rm_p0, rd_p0;
    logic [1:0]  mode_p0;
    logic        imm_p0, s_bit_p0, l_bit_p0, pass_p0, is_str_p0;
    logic        wb_en_p0, mem_r_en_p0, mem_w_en_p0, b_p0, s_p0;
    logic [3:0]  exe_cmd_p0;
    logic [3:0]  src2_p0;
    logic [DATA_W-1:0] val_rn_p0, val_rm_p0;

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] sr);
        logic n, z, c, v;
        {n, z, c, v} = sr;
        case (cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c && !z;
            4'b1001: cond_pass = !c || z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z && (n == v);
            4'b1101: cond_pass = z || (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    // Index 15 is the PC; a read of the entry being written sees the new value.
    function automatic logic [DATA_W-1:0] rf_read(
        input logic [3:0]        addr,
        input logic [DATA_W-1:0] pc,
        input logic              we,
        input logic [3:0]        waddr,
        input logic [DATA_W-1:0] wdata
    );
        if (addr == 4'd15)
            rf_read = pc;
        else if (we && waddr == addr)
            rf_read = wdata;
        else
            rf_read = rf[addr];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
        end else if (bus.WB_WB_EN && bus.WB_Dest < 4'(REG_COUNT)) begin
            rf[bus.WB_Dest] <= bus.WB_Value;
        end
    end

    assign cond_p0   = bus.Instruction[31:28];
    assign mode_p0   = bus.Instruction[27:26];
    assign imm_p0    = bus.Instruction[25];
    assign opcode_p0 = bus.Instruction[24:21];
    assign s_bit_p0  = bus.Instruction[20];
    assign l_bit_p0  = bus.Instruction[20];
    assign rn_p0     = bus.Instruction[19:16];
    assign rd_p0     = bus.Instruction[15:12];
    assign rm_p0     = bus.Instruction[3:0];
    assign is_str_p0 = (mode_p0 == 2'b01) && !l_bit_p0;
    assign src2_p0   = is_str_p0 ? rd_p0 : rm_p0;
    assign pass_p0   = cond_pass(cond_p0, bus.SR);

    assign bus.src1    = rn_p0;
    assign bus.src2    = src2_p0;
    assign bus.Two_src = !imm_p0 || is_str_p0;

    assign val_rn_p0 = rf_read(rn_p0,   bus.PC_in, bus.WB_WB_EN, bus.WB_Dest, bus.WB_Value);
    assign val_rm_p0 = rf_read(src2_p0, bus.PC_in, bus.WB_WB_EN, bus.WB_Dest, bus.WB_Value);

    always_comb begin
        wb_en_p0    = 1'b0;
        mem_r_en_p0 = 1'b0;
        mem_w_en_p0 = 1'b0;
        b_p0        = 1'b0;
        s_p0        = 1'b0;
        exe_cmd_p0  = 4'b0000;
        case (mode_p0)
            2'b00: begin
                wb_en_p0 = 1'b1;
                s_p0     = s_bit_p0;
                case (opcode_p0)
                    4'b1101: exe_cmd_p0 = 4'b0001;
                    4'b1111: exe_cmd_p0 = 4'b1001;
                    4'b0100: exe_cmd_p0 = 4'b0010;
                    4'b0101: exe_cmd_p0 = 4'b0011;
                    4'b0010: exe_cmd_p0 = 4'b0100;
                    4'b0110: exe_cmd_p0 = 4'b0101;
                    4'b0000: exe_cmd_p0 = 4'b0110;
                    4'b1100: exe_cmd_p0 = 4'b0111;
                    4'b0001: exe_cmd_p0 = 4'b1000;
                    4'b1010: begin exe_cmd_p0 = 4'b0100; wb_en_p0 = 1'b0; end
                    4'b1000: begin exe_cmd_p0 = 4'b0110; wb_en_p0 = 1'b0; end
                    default: begin wb_en_p0 = 1'b0; s_p0 = 1'b0; end
                endcase
            end
            2'b01: begin
                exe_cmd_p0  = 4'b0010;
                mem_r_en_p0 = l_bit_p0;
                wb_en_p0    = l_bit_p0;
                mem_w_en_p0 = !l_bit_p0;
            end
            2'b10:   b_p0 = 1'b1;
            default: ;
        endcase
        // Failed condition or stall turns the instruction into a bubble; data still flows.
        if (!pass_p0 || bus.hazard) begin
            wb_en_p0    = 1'b0;
            mem_r_en_p0 = 1'b0;
            mem_w_en_p0 = 1'b0;
            b_p0        = 1'b0;
            s_p0        = 1'b0;
            exe_cmd_p0  = 4'b0000;
        end
    end

    // ID/EX boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst || (!rst && bus.flush)) begin
            bus.WB_EN         <= 1'b0;
            bus.MEM_R_EN      <= 1'b0;
            bus.MEM_W_EN      <= 1'b0;
            bus.B             <= 1'b0;
            bus.S             <= 1'b0;
            bus.EXE_CMD       <= '0;
            bus.Val_Rn        <= '0;
            bus.Val_Rm        <= '0;
            bus.imm           <= 1'b0;
            bus.Shift_operand <= '0;
            bus.Signed_imm_24 <= '0;
            bus.Dest          <= '0;
            bus.PC_out        <= '0;
        end else if (!bus.freeze) begin
            bus.WB_EN         <= wb_en_p0;
            bus.MEM_R_EN      <= mem_r_en_p0;
            bus.MEM_W_EN      <= mem_w_en_p0;
            bus.B             <= b_p0;
            bus.S             <= s_p0;
            bus.EXE_CMD       <= exe_cmd_p0;
            bus.Val_Rn        <= val_rn_p0;
            bus.Val_Rm        <= val_rm_p0;
            bus.imm           <= imm_p0;
            bus.Shift_operand <= bus.Instruction[11:0];
            bus.Signed_imm_24 <= bus.Instruction[23:0];
            bus.Dest          <= rd_p0;
            bus.PC_out        <= bus.PC_in;
        end
    end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage ARM-subset pipeline, directly downstream of the instruction-fetch stage.
- Consumes fetched PC and Instruction from the IF/ID boundary.
- Decodes control, reads a 15-entry register file written by writeback, and evaluates the condition field against the status register.
- Drives a registered ID/EX bundle to the execute stage.

Parameters:
- DATA_W, 32, datapath and register width
- REG_COUNT, 15, architectural registers R0..R14 (index 15 maps to PC)

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- PC_in  in  32  PC of the instruction in ID (IF already added 4)
- Instruction  in  32  instruction word from IF/ID
- freeze  in  1  hold the ID/EX register
- flush  in  1  branch taken; insert bubble into ID/EX
- hazard  in  1  hazard-unit stall; control outputs zeroed for this cycle
- SR  in  4  status flags {N,Z,C,V} from execute
- WB_WB_EN  in  1  register-file write enable
- WB_Dest  in  4  write address
- WB_Value  in  32  write data
- src1  out  4  Rn = Instruction[19:16], combinational
- src2  out  4  Rm = Instruction[3:0]; Rd = Instruction[15:12] when the instruction is STR; combinational
- Two_src  out  1  (~I) | MEM_W_EN, combinational
- WB_EN, MEM_R_EN, MEM_W_EN, B, S  out  1 each  registered control
- EXE_CMD  out  4  registered ALU command
- Val_Rn, Val_Rm  out  32 each  registered operands
- imm  out  1  registered I bit (Instruction[25])
- Shift_operand  out  12  registered Instruction[11:0]
- Signed_imm_24  out  24  registered Instruction[23:0]
- Dest  out  4  registered Instruction[15:12]
- PC_out  out  32  registered PC_in

Behaviour:
- Reset (async): all registered outputs 0; all register-file entries 0.
- Register file:
  - Writes at the rising edge when WB_WB_EN=1 and WB_Dest<15.
  - WB_Dest=15 writes are ignored.
  - Reads are combinational.
  - Same-cycle read of the address being written returns WB_Value (write-through bypass).
  - A read of index 15 returns PC_in.
- Decode by mode = Instruction[27:26]:
  - 00 data-processing; opcode = Instruction[24:21], S = Instruction[20]. EXE_CMD/WB_EN by opcode:
    - MOV 1101 -> 0001/1
    - MVN 1111 -> 1001/1
    - ADD 0100 -> 0010/1
    - ADC 0101 -> 0011/1
    - SUB 0010 -> 0100/1
    - SBC 0110 -> 0101/1
    - AND 0000 -> 0110/1
    - ORR 1100 -> 0111/1
    - EOR 0001 -> 1000/1
    - CMP 1010 -> 0100/0
    - TST 1000 -> 0110/0
    - Any other opcode -> all control 0.
  - 01 memory; EXE_CMD 0010, S forced 0.
    - L=Instruction[20]=1: LDR (MEM_R_EN=1, WB_EN=1).
    - L=0: STR (MEM_W_EN=1).
  - 10 branch; B=1, all other control 0.
  - 11 -> all control 0.
- Condition (Instruction[31:28]):
  - Standard ARM encoding 0000 EQ through 1110 AL, evaluated on SR.
  - 1111 is treated as fail.
- Control gating: condition fail or hazard=1 -> WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD all 0 in the value loaded. Data fields (Val_Rn, Val_Rm, Dest, PC_out, etc.) still load.
- ID/EX register update at each rising edge, priority rst > flush > freeze > load:
  - flush: every output field 0.
  - freeze: every output holds.
  - load: latency is 1 cycle from Instruction/PC_in to outputs.
- Register-file writes proceed regardless of freeze, flush or hazard.
- Reset asserted mid-operation clears the register file and the ID/EX register immediately, without waiting for a clock edge.

Test Plan:
- rst=1 with random inputs -> all outputs 0. Release; read any register -> 0.
- Write R2=5, R3=7 via WB; then Instruction=0xE0821003 (ADD R1,R2,R3), PC_in=0x10 -> next edge: EXE_CMD=0010, WB_EN=1, Val_Rn=5, Val_Rm=7, Dest=1, PC_out=0x10, Two_src=1.
- Instruction=0x00821003 (ADDEQ) with SR=0000 -> all control 0, Dest=1. Same instruction with SR=0100 -> WB_EN=1.
- Instruction=0xEA000004 -> B=1, Signed_imm_24=0x000004, WB_EN=0. Instruction=0xE5821000 (STR R1,[R2]) -> MEM_W_EN=1, src2=1, Two_src=1.
- WB writes R2=0xAA in the same cycle ID reads R2 -> Val_Rn=0xAA. WB_Dest=15 -> no register changes.
- Load ADD, then freeze=1 for 2 cycles with new Instruction -> outputs unchanged. flush=1 together with freeze=1 -> all outputs 0 next edge. hazard=1 -> control 0, Val_Rn still loads.
